pad_share_sched: RTL and testbench
==================================

Name: pad_share_sched

Overview:
- Time-multiplexes one bidirectional IO pad (BB-style primitive: PADDO output, T tristate control, PADDI input) between N_REQ requesters.
- Each requester asks for a serial write burst (drive pad) or read burst (sample pad) of len+1 bits.
- Round-robin arbitration; turnaround cycles with the pad released whenever direction changes.
- Sits between protocol engines and the pad cell; pad_t follows primitive convention (1 = high-Z).

Parameters:
N_REQ, 4, number of requesters (2..8)
LEN_W, 4, burst-length field width; burst = len+1 bits (1..2^LEN_W)
TURN_CYC, 2, high-Z turnaround cycles inserted on direction change (0..7; 0 = none)

Ports:
clk  in  1  single clock
rst  in  1  reset, synchronous, active-high
req  in  N_REQ  per-requester transfer request; level, sampled only in IDLE
req_dir  in  N_REQ  per-requester direction: 1 = write (drive pad), 0 = read
req_len  in  N_REQ*LEN_W  per-requester length-1, requester i at bits [i*LEN_W +: LEN_W]
wr_data  in  N_REQ  per-requester write bit, valid when its beat bit is high
grant  out  N_REQ  one-hot owner of the pad, high from grant through done
beat  out  N_REQ  one-hot, high in each transfer cycle; requester presents/consumes one bit
done  out  N_REQ  one-cycle pulse to owner after its last bit
rd_data  out  1  sampled pad bit
rd_valid  out  1  rd_data valid (read bursts only)
pad_o  out  1  to primitive PADDO
pad_t  out  1  to primitive T; 1 = high-Z
pad_i  in  1  from primitive PADDI

Behaviour:
- Reset values: grant=0, beat=0, done=0, rd_valid=0, rd_data=0, pad_o=0, pad_t=1, state IDLE, rr_ptr=0, last_dir=read(0), counters 0.
- Reset asserted mid-burst: all of the above on the next edge; no done pulse; the pad is released (pad_t=1) that edge.
- States: IDLE, TURN, XFER.
- IDLE:
  - If any req bit is set, select the first set index starting at rr_ptr, wrapping modulo N_REQ.
  - Latch cur = index, cur_dir = req_dir[cur], cnt = req_len[cur].
  - Next cycle: grant[cur]=1 and state = TURN if (cur_dir != last_dir and TURN_CYC>0), else XFER.
  - If no req bit is set, remain in IDLE.
- TURN:
  - pad_t held 1; grant held.
  - Stay exactly TURN_CYC cycles, then go to XFER.
- XFER:
  - beat[cur]=1 every cycle for exactly len+1 cycles; cnt decrements each beat.
  - On the cycle with cnt==0, next state is IDLE.
- Pad path, all registered with 1-cycle latency from the beat cycle:
  - pad_o <= (beat active and cur_dir write) ? wr_data[cur] : 0
  - pad_t <= !(beat active and cur_dir write)
  - rd_data <= pad_i and rd_valid <= (beat active and cur_dir read)
  - pad_t is low exactly len+1 consecutive cycles per write burst, aligned with pad_o bits.
- Completion:
  - The cycle after the last beat: done[cur]=1 for one cycle and grant drops to 0.
  - That cycle is also the last pad_o bit / last rd_valid.
  - On that same edge: last_dir <= cur_dir, rr_ptr <= (cur+1) mod N_REQ.
- Arbitration point: the done cycle is spent in IDLE, so arbitration happens then. This gives a minimum of one non-granted cycle between bursts.
- Request sampling:
  - req, req_dir and req_len are ignored outside IDLE.
  - Deasserting req mid-burst does not abort the burst.
  - A requester holding req across its done pulse is rearbitrated with its rr priority moved last.
- No direction change means no TURN state. The first-ever write after reset gets a turnaround, because last_dir resets to read.
- Invariants: at most one grant bit set; beat implies grant on the same index; pad_t=0 never coincides with a TURN cycle.

Test Plan:
- Reset: hold rst 3 cycles with req=4'b1111 -> grant=0, beat=0, done=0, pad_t=1, pad_o=0 throughout.
- Single write: req[1]=1, dir=1, len=3, bits 1,0,1,1 -> grant[1] at T+1; 2 TURN cycles with pad_t=1; beat[1] for 4 cycles; pad_o=1,0,1,1 with pad_t=0 exactly those 4 cycles; done[1] coincides with the last bit.
- Write then read: req0 write len=0 done, then req2 read len=2 with pad_i=0,1,1 -> 2 high-Z TURN cycles before read beats; rd_valid 3 cycles with rd_data=0,1,1; pad_t=1 throughout the read.
- Round robin: all four requesting same-direction writes, len=0, held continuously -> grant order 0,1,2,3,0; no TURN after the first burst; exactly 1 ungranted cycle between bursts.
- Reset mid-write: assert rst during the 3rd beat of a len=7 write -> next cycle pad_t=1, grant=0, no done pulse; after release, the next write to rr_ptr=0 gets 2 TURN cycles.
- Mid-burst req drop: req3 read len=5, deassert req3 after the first beat -> all 6 beats and done[3] still occur.

Source files
------------

// File: rtl/pad_share_sched.sv
// rtl/pad_share_sched.sv - round-robin scheduler sharing one bidirectional pad between serial requesters
module pad_share_sched #(
  parameter int N_REQ    = 4,
  parameter int LEN_W    = 4,
  parameter int TURN_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       req_dir,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  input  logic [N_REQ-1:0]       wr_data,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       beat,
  output logic [N_REQ-1:0]       done,
  output logic                   rd_data,
  output logic                   rd_valid,
  output logic                   pad_o,
  output logic                   pad_t,
  input  logic                   pad_i
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TC_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PTR_W-1:0]  cur;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_nxt;
  logic [PTR_W-1:0]  sel_idx;
  logic              sel_found;
  logic              cur_dir;
  logic              last_dir;
  logic [LEN_W-1:0]  cnt;
  logic [TC_W-1:0]   tcnt;
  logic [N_REQ-1:0]  cur_oh;
  logic              xfer_wr;
  logic              xfer_rd;
  logic              last_beat;

  // Round-robin pick: first requesting index at or after rr_ptr, wrapping.
  always_comb begin : arb
    int j;
    sel_found = 1'b0;
    sel_idx   = '0;
    j         = 0;
    // Walk from the farthest candidate down so the nearest one wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(j);
      end
    end
  end

  // Owner decode and beat qualifiers shared by the FSM outputs and pad path.
  always_comb begin
    cur_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << cur;
    xfer_wr   = (state == ST_XFER) && cur_dir;
    xfer_rd   = (state == ST_XFER) && !cur_dir;
    last_beat = (state == ST_XFER) && (cnt == '0);
    rr_nxt    = (int'(cur) == N_REQ - 1) ? '0 : cur + 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and grant/beat decode; the done cycle lands in IDLE so it doubles as the arbitration cycle.
  always_comb begin
    state_nxt = state;
    grant     = '0;
    beat      = '0;
    case (state)
      ST_IDLE: begin
        if (sel_found) begin
          if ((req_dir[sel_idx] != last_dir) && (TURN_CYC > 0)) state_nxt = ST_TURN;
          else                                                  state_nxt = ST_XFER;
        end
      end
      ST_TURN: begin
        grant = cur_oh;
        if (tcnt == '0) state_nxt = ST_XFER;
      end
      ST_XFER: begin
        grant = cur_oh;
        beat  = cur_oh;
        if (cnt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Burst bookkeeping: latch the winner, count turnaround and beats, rotate priority on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= '0;
      cur_dir  <= 1'b0;
      cnt      <= '0;
      tcnt     <= '0;
      last_dir <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            cur     <= sel_idx;
            cur_dir <= req_dir[sel_idx];
            cnt     <= req_len[int'(sel_idx)*LEN_W +: LEN_W];
            tcnt    <= TC_W'(TURN_CYC - 1);
          end
        end
        ST_TURN: begin
          if (tcnt != '0) tcnt <= tcnt - 1'b1;
        end
        ST_XFER: begin
          if (cnt == '0) begin
            last_dir <= cur_dir;
            rr_ptr   <= rr_nxt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered pad path and done pulse, one cycle behind the beat that produced them.
  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= '0;
      pad_o    <= 1'b0;
      pad_t    <= 1'b1;
      rd_data  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      done     <= last_beat ? cur_oh : '0;
      pad_o    <= xfer_wr ? wr_data[cur] : 1'b0;
      pad_t    <= !xfer_wr;
      rd_data  <= pad_i;
      rd_valid <= xfer_rd;
    end
  end

endmodule

// File: tb/tb_pad_share_sched.sv
// tb/tb_pad_share_sched.sv - self-checking bench for pad_share_sched
module tb_pad_share_sched;

  localparam int N     = 4;
  localparam int TURN  = 2;
  localparam int N_CYC = 2500;
  localparam int NA    = N_CYC + 64;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_dir;
  logic [15:0] req_len;
  logic [3:0]  wr_data;
  logic [3:0]  grant;
  logic [3:0]  beat;
  logic [3:0]  done;
  logic        rd_data;
  logic        rd_valid;
  logic        pad_o;
  logic        pad_t;
  logic        pad_i;

  int n_cmp = 0;
  int n_bad = 0;

  pad_share_sched #(.N_REQ(N), .LEN_W(4), .TURN_CYC(TURN)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dir(req_dir), .req_len(req_len),
    .wr_data(wr_data), .grant(grant), .beat(beat), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .pad_o(pad_o), .pad_t(pad_t), .pad_i(pad_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    bit dir;
    int len;
    int bits;
    int exp_turn;
    int exp_done;
    int exp_lowz;
  } vec_t;

  vec_t tbl [7];

  logic [3:0] eg  [0:NA-1];
  logic [3:0] eb  [0:NA-1];
  logic [3:0] ed  [0:NA-1];
  logic       ept [0:NA-1];
  logic       epo [0:NA-1];
  logic       erv [0:NA-1];
  logic       erd [0:NA-1];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    rst = 1'b0;
  endtask

  // Single requester burst from IDLE; measures latency, beats, pad activity and done timing.
  task automatic run_burst(input vec_t v, input string tag);
    logic [3:0] oh;
    int t, nbeat, first_beat, nlow, nrv, done_cyc, cap_o, cap_r, mask;
    logic [3:0] grant_at_done, done_val;
    oh = 4'b0001 << v.id;
    mask = (1 << (v.len + 1)) - 1;
    req = oh;
    req_dir = v.dir ? oh : 4'b0;
    req_len = 16'(v.len) << (4 * v.id);
    wr_data = 4'b0;
    pad_i = 1'b0;
    step();
    req = 4'b0;
    check({tag, "_grant"}, grant, oh);
    nbeat = 0; first_beat = -1; nlow = 0; nrv = 0; done_cyc = -1;
    cap_o = 0; cap_r = 0; grant_at_done = 4'hF; done_val = 4'h0;
    t = 1;
    while (done_cyc < 0 && t <= 40) begin
      if (!pad_t) begin cap_o |= int'(pad_o) << nlow; nlow++; end
      if (rd_valid) begin cap_r |= int'(rd_data) << nrv; nrv++; end
      if (done != 4'b0) begin done_cyc = t; grant_at_done = grant; done_val = done; end
      if (beat == oh) begin
        if (first_beat < 0) first_beat = t;
        wr_data = v.bits[nbeat] ? oh : 4'b0;
        pad_i = v.bits[nbeat];
        nbeat++;
      end else begin
        wr_data = 4'b0;
        pad_i = 1'b0;
      end
      if (done_cyc < 0) begin step(); t++; end
    end
    check({tag, "_first_beat"}, first_beat, 1 + v.exp_turn);
    check({tag, "_beats"}, nbeat, v.len + 1);
    check({tag, "_padt_low"}, nlow, v.exp_lowz);
    if (v.dir) check({tag, "_pad_o_bits"}, cap_o, v.bits & mask);
    else begin
      check({tag, "_rd_valid_cnt"}, nrv, v.len + 1);
      check({tag, "_rd_data_bits"}, cap_r, v.bits & mask);
    end
    check({tag, "_done_cycle"}, done_cyc, v.exp_done);
    check({tag, "_done_owner"}, done_val, oh);
    check({tag, "_grant_at_done"}, grant_at_done, 0);
    step();
    check({tag, "_after"}, {done, pad_t, rd_valid}, {4'b0, 1'b1, 1'b0});
  endtask

  initial begin : main
    logic [3:0]  rec_g [5];
    int          rec_t [5];
    int          nrec, t, ndone, nbeat, nrv, done_cyc;
    logic [3:0]  prev_g;
    int          m_next, m_rr, w, turn, len, bstart, bend, dd;
    bit          m_last_dir, b_active, b_dir, found;
    int          b_w;
    logic [14:0] act, expv;
    int          exp_g [5];
    int          exp_t [5];

    tbl[0] = '{1, 1'b1, 3,  'hD,    2, 7,  4};
    tbl[1] = '{0, 1'b1, 0,  'h1,    0, 2,  1};
    tbl[2] = '{2, 1'b0, 2,  'h6,    2, 6,  0};
    tbl[3] = '{3, 1'b0, 15, 'hA5C3, 0, 17, 0};
    tbl[4] = '{0, 1'b1, 7,  'h5A,   2, 11, 8};
    tbl[5] = '{3, 1'b1, 1,  'h2,    0, 3,  2};
    tbl[6] = '{1, 1'b0, 0,  'h1,    2, 4,  0};

    rst = 1'b1; req = 4'hF; req_dir = 4'hF; req_len = 16'h0; wr_data = 4'hF; pad_i = 1'b1;

    // Reset held three cycles with every requester asking.
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_outputs", {grant, beat, done, pad_t, pad_o, rd_valid}, {12'h000, 1'b1, 1'b0, 1'b0});
    end
    rst = 1'b0; req = 4'h0; wr_data = 4'h0; pad_i = 1'b0;
    step();

    // Table of isolated bursts.
    for (int i = 0; i < 7; i++) run_burst(tbl[i], $sformatf("vec%0d", i));

    // Round robin, all writing len=0 and holding req.
    exp_g = '{1, 2, 4, 8, 1};
    exp_t = '{1, 5, 7, 9, 11};
    do_reset(1);
    req = 4'hF; req_dir = 4'hF; req_len = 16'h0; wr_data = 4'hA;
    nrec = 0; prev_g = 4'b0;
    for (t = 1; t <= 30 && nrec < 5; t++) begin
      step();
      if (grant != 4'b0 && prev_g == 4'b0) begin rec_g[nrec] = grant; rec_t[nrec] = t; nrec++; end
      if (nrec == 5) req = 4'h0;
      prev_g = grant;
    end
    check("rr_grants_seen", nrec, 5);
    for (int i = 0; i < nrec; i++) begin
      check($sformatf("rr_owner%0d", i), rec_g[i], exp_g[i]);
      check($sformatf("rr_start%0d", i), rec_t[i], exp_t[i]);
    end
    req = 4'h0;
    for (int i = 0; i < 4; i++) step();

    // Reset during the third beat of a len=7 write.
    req = 4'b0100; req_dir = 4'b0100; req_len = 16'h0700; wr_data = 4'b0100;
    step(); req = 4'h0;
    step(); step();
    check("rstmid_beat3", beat, 4'b0100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_released", {grant, beat, done, pad_t}, {12'h000, 1'b1});
    ndone = 0;
    for (int i = 0; i < 10; i++) begin step(); if (done != 4'b0) ndone++; end
    check("rstmid_no_done", ndone, 0);
    req = 4'b0011; req_dir = 4'b0011; req_len = 16'h0; wr_data = 4'h0;
    step(); req = 4'h0;
    check("rstmid_next_grant", grant, 4'b0001);
    step();
    check("rstmid_turn1", {beat, pad_t}, {4'b0, 1'b1});
    step();
    check("rstmid_turn_then_beat", beat, 4'b0001);
    step();
    check("rstmid_done", done, 4'b0001);
    step();

    // Requester 3 drops req after its first read beat.
    req = 4'b1000; req_dir = 4'b0; req_len = 16'h5000; pad_i = 1'b0;
    nbeat = 0; ndone = 0; nrv = 0; done_cyc = -1;
    for (t = 1; t <= 20; t++) begin
      step();
      if (beat == 4'b1000) begin nbeat++; if (nbeat == 1) req = 4'h0; end
      if (rd_valid) nrv++;
      if (done == 4'b1000) begin ndone++; done_cyc = t; end
    end
    req = 4'h0;
    check("drop_beats", nbeat, 6);
    check("drop_rd_valid", nrv, 6);
    check("drop_done_count", ndone, 1);
    check("drop_done_cycle", done_cyc, 9);

    // Randomized traffic against a burst-schedule reference model.
    for (int i = 0; i < NA; i++) begin
      eg[i] = 4'b0; eb[i] = 4'b0; ed[i] = 4'b0; ept[i] = 1'b1; epo[i] = 1'b0; erv[i] = 1'b0; erd[i] = 1'b0;
    end
    do_reset(1);
    m_next = 0; m_rr = 0; m_last_dir = 1'b0; b_active = 1'b0; b_dir = 1'b0; b_w = 0; bstart = 0; bend = -1;
    for (int c = 0; c < N_CYC; c++) begin
      act  = {grant, beat, done, pad_t, pad_o, rd_valid};
      expv = {eg[c], eb[c], ed[c], ept[c], epo[c], erv[c]};
      check("rand_outputs", int'(act), int'(expv));
      if (erv[c]) check("rand_rd_data", rd_data, erd[c]);

      req = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      req_dir = 4'($urandom);
      for (int i = 0; i < N; i++)
        req_len[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      wr_data = 4'($urandom);
      pad_i = 1'($urandom);

      if (b_active && c >= bstart && c <= bend) begin
        epo[c+1] = b_dir ? wr_data[b_w] : 1'b0;
        ept[c+1] = !b_dir;
        erv[c+1] = !b_dir;
        erd[c+1] = pad_i;
      end

      if (c == m_next) begin
        found = 1'b0; w = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && req[(m_rr + k) % N]) begin found = 1'b1; w = (m_rr + k) % N; end
        end
        if (found) begin
          b_dir = req_dir[w];
          len = int'(req_len[4*w +: 4]);
          turn = (b_dir != m_last_dir) ? TURN : 0;
          for (int x = c + 1; x <= c + 1 + turn + len; x++) eg[x] = 4'b0001 << w;
          bstart = c + 1 + turn;
          bend = bstart + len;
          for (int x = bstart; x <= bend; x++) eb[x] = 4'b0001 << w;
          dd = bend + 1;
          ed[dd] = 4'b0001 << w;
          b_w = w; b_active = 1'b1;
          m_next = dd;
          m_last_dir = b_dir;
          m_rr = (w + 1) % N;
        end else begin
          m_next = c + 1;
        end
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
